// File: rtl/uart_transmitter.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s),
// timed by a 16x oversampling tick. tx, tx_busy and tx_doneTick all come straight from flops.
module uart_transmitter #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_dataIn,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_doneTick
);

  // Tick counter grows to 5 bits so stop periods of up to 32 ticks fit.
  localparam int CW = (SB_TICK > 16) ? 5 : 4;
  localparam logic [CW-1:0] TICK_LAST = CW'(15);
  localparam logic [CW-1:0] SB_LAST   = CW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);
  localparam logic          ODD_BIT   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] s_cnt_r, s_cnt_s;
  logic [2:0]    n_cnt_r, n_cnt_s;
  logic [7:0]    b_r, b_s;
  logic          par_r, par_s;
  logic          tx_r, tx_s;
  logic          busy_r;
  logic          done_r, done_s;

  // Next-state, counter, shift-register and parity logic.
  always_comb begin
    state_s = state_r;
    s_cnt_s = s_cnt_r;
    n_cnt_s = n_cnt_r;
    b_s     = b_r;
    par_s   = par_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          b_s     = tx_dataIn;
          s_cnt_s = '0;
          par_s   = 1'b0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_r == TICK_LAST) begin
            s_cnt_s = '0;
            n_cnt_s = 3'd0;
            state_s = DATA;
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_r == TICK_LAST) begin
            par_s   = par_r ^ b_r[0];
            b_s     = {1'b0, b_r[7:1]};
            s_cnt_s = '0;
            if (n_cnt_r == N_LAST) begin
              state_s = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_cnt_s = n_cnt_r + 3'd1;
            end
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_r == TICK_LAST) begin
            s_cnt_s = '0;
            state_s = STOP;
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_r == SB_LAST) begin
            s_cnt_s = '0;
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Line level is decoded from the upcoming state so the tx flop changes with it.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = b_s[0];
      PARITY:  tx_s = par_s ^ ODD_BIT;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      s_cnt_r <= '0;
      n_cnt_r <= 3'd0;
      b_r     <= 8'h00;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      s_cnt_r <= s_cnt_s;
      n_cnt_r <= n_cnt_s;
      b_r     <= b_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
    end
  end

  assign tx          = tx_r;
  assign tx_busy     = busy_r;
  assign tx_doneTick = done_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: four parameterisations driven in parallel,
// frames decoded from the line and compared with an expected bit list built from the byte.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_w, busy_w, done_w;

  int n_tests = 0;
  int n_fail  = 0;
  int period  = 4;
  int tcnt    = 0;

  always #5 clk = ~clk;

  // Config 0: defaults; 1: even parity; 2: odd parity; 3: two stop bits.
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start), .tx_dataIn(tx_data),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_doneTick(done_w[0]));
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_pev (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start), .tx_dataIn(tx_data),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_doneTick(done_w[1]));
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_pod (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start), .tx_dataIn(tx_data),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_doneTick(done_w[2]));
  uart_transmitter #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_sb2 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start), .tx_dataIn(tx_data),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_doneTick(done_w[3]));

  function automatic int pen(int k); return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int odd(int k); return (k == 2) ? 1 : 0; endfunction
  function automatic int sbt(int k); return (k == 3) ? 32 : 16; endfunction
  function automatic int nslots(int k); return 9 + pen(k) + sbt(k) / 16; endfunction
  function automatic int frame_len(int k); return 16 * (9 + pen(k)) + sbt(k); endfunction

  // Expected line level per 16-tick slot: start, 8 data LSB first, [parity], stop slot(s).
  function automatic logic [15:0] exp_bits(logic [7:0] d, int k);
    logic [15:0] v;
    int idx;
    v = 16'h0000;
    for (int i = 0; i < 8; i++) v[1 + i] = d[i];
    idx = 9;
    if (pen(k) == 1) begin
      v[9] = (^d) ^ (odd(k) == 1);
      idx = 10;
    end
    for (int s = 0; s < sbt(k) / 16; s++) v[idx + s] = 1'b1;
    return v;
  endfunction

  // Oversampling tick, one clk wide every `period` clocks (period 1 keeps it high).
  always @(posedge clk) begin
    #1;
    if (tcnt >= period - 1) begin
      tcnt = 0;
      s_tick = 1'b1;
    end else begin
      tcnt++;
      s_tick = 1'b0;
    end
  end

  // Line monitor: counts ticks from the falling start edge and samples mid-slot.
  int          c [4];
  bit          act [4];
  logic [15:0] cur [4];
  int          idle_cnt [4];
  int          nf [4];
  logic [15:0] fbits [4][64];
  int          fticks [4][64];
  int          fgap [4][64];
  int          stray [4];
  int          busy_err [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        act[k] = 1'b0;
        idle_cnt[k] = 0;
      end else if (act[k]) begin
        if (done_w[k]) begin
          if (nf[k] < 64) begin
            fbits[k][nf[k]]  = cur[k];
            fticks[k][nf[k]] = c[k];
          end
          nf[k]++;
          act[k] = 1'b0;
          idle_cnt[k] = 1;
        end else begin
          if (c[k] % 16 == 8 && c[k] / 16 < 16) cur[k][c[k] / 16] = tx_w[k];
          if (s_tick) c[k]++;
        end
      end else if (tx_w[k] == 1'b0) begin
        act[k] = 1'b1;
        c[k] = s_tick ? 1 : 0;
        cur[k] = 16'h0000;
        if (nf[k] < 64) fgap[k][nf[k]] = idle_cnt[k];
      end else begin
        idle_cnt[k]++;
        if (done_w[k]) stray[k]++;
      end
      if (busy_w[k] != act[k]) busy_err[k]++;
    end
  end

  task automatic chk(string nm, int actual, int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, actual, actual, expected, expected);
    end
  endtask

  task automatic wait_all_idle(int maxc);
    int n = 0;
    while (busy_w != 4'b0000 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy_w != 4'b0000), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(string nm, int k, int idx, logic [7:0] d);
    logic [15:0] m;
    m = (16'h0001 << nslots(k)) - 16'h0001;
    chk($sformatf("%s_bits_c%0d", nm, k), int'(fbits[k][idx] & m), int'(exp_bits(d, k) & m));
    chk($sformatf("%s_ticks_c%0d", nm, k), fticks[k][idx], frame_len(k));
  endtask

  task automatic send_frame(string nm, logic [7:0] d);
    int base [4];
    for (int k = 0; k < 4; k++) base[k] = nf[k];
    @(posedge clk); #1;
    tx_data = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_all_idle(5000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_count_c%0d", nm, k), nf[k] - base[k], 1);
      if (nf[k] > base[k]) check_frame(nm, k, nf[k] - 1, d);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    int         per;
  } vec_t;

  vec_t vecs [9];
  int   base [4];
  int   n;

  initial begin
    vecs[0] = '{8'h55, 1'b0, 4};
    vecs[1] = '{8'h0F, 1'b0, 1};
    vecs[2] = '{8'hFF, 1'b0, 2};
    vecs[3] = '{8'h07, 1'b1, 3};
    vecs[4] = '{8'h00, 1'b0, 5};
    vecs[5] = '{8'hA5, 1'b0, 4};
    vecs[6] = '{8'h80, 1'b1, 2};
    vecs[7] = '{8'h01, 1'b1, 6};
    vecs[8] = '{8'h3C, 1'b0, 1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx_w), 15);
    chk("rst_busy", int'(busy_w), 0);
    chk("rst_done", int'(done_w), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_tx", int'(tx_w), 15);
    chk("post_rst_busy", int'(busy_w), 0);

    // Table-driven frames, with the tabulated even-parity bit checked directly.
    for (int i = 0; i < 9; i++) begin
      period = vecs[i].per;
      send_frame($sformatf("vec%0d", i), vecs[i].data);
      chk($sformatf("vec%0d_par_even", i), int'(fbits[1][nf[1] - 1][9]), int'(vecs[i].par_even));
      chk($sformatf("vec%0d_par_odd", i), int'(fbits[2][nf[2] - 1][9]), int'(!vecs[i].par_even));
    end

    // Randomized bytes and tick rates against the frame model.
    for (int i = 0; i < 6; i++) begin
      period = $urandom_range(1, 6);
      send_frame($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)));
    end

    // Back-to-back: tx_start held high, data switched after the first latch.
    period = 3;
    for (int k = 0; k < 4; k++) base[k] = nf[k];
    @(posedge clk); #1;
    tx_data = 8'h0F;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    n = 0;
    while (!(nf[0] > base[0] && nf[1] > base[1] && nf[2] > base[2] && nf[3] > base[3]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_all_idle(5000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_count_c%0d", k), nf[k] - base[k], 2);
      if (nf[k] >= base[k] + 2) begin
        check_frame("b2b_first", k, base[k], 8'h0F);
        check_frame("b2b_second", k, base[k] + 1, 8'hFF);
        chk($sformatf("b2b_gap_c%0d", k), fgap[k][base[k] + 1], 1);
      end
    end

    // tx_start during DATA is ignored and the frame in flight keeps its byte.
    period = 2;
    for (int k = 0; k < 4; k++) base[k] = nf[k];
    @(posedge clk); #1;
    tx_data = 8'h3C;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    tx_data = 8'hA5;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_all_idle(5000);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ign_count_c%0d", k), nf[k] - base[k], 1);
      if (nf[k] > base[k]) check_frame("ign", k, base[k], 8'h3C);
    end

    // Asynchronous reset mid-frame aborts with no done tick.
    for (int k = 0; k < 4; k++) base[k] = nf[k];
    @(posedge clk); #1;
    tx_data = 8'h55;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (60) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_tx", int'(tx_w), 15);
    chk("abort_busy", int'(busy_w), 0);
    chk("abort_done", int'(done_w), 0);
    #10 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle_tx", int'(tx_w), 15);
    chk("abort_idle_busy", int'(busy_w), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("abort_count_c%0d", k), nf[k] - base[k], 0);
    send_frame("recover", 8'hC3);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stray_done_c%0d", k), stray[k], 0);
      chk($sformatf("busy_track_c%0d", k), busy_err[k], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART TX serializer: the transmit-side counterpart of the receiver.
- Takes a parallel byte from the TX FIFO/APB side and shifts it out on `tx` as start bit, LSB-first data, optional parity, then stop bit(s).
- Bit timing comes from the shared baud-rate generator's 16x oversampling `s_tick` (divsr 650 @ 100 MHz clk gives 9600 baud).
- Signals completion with a one-cycle done tick, which the FIFO uses as its read strobe.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, stop-bit length in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- s_tick  input  1  16x oversampling enable pulse from the baud generator, one clk wide.
- tx_start  input  1  request to send tx_dataIn; sampled only in IDLE.
- tx_dataIn  input  8  byte to transmit; bits [DBIT-1:0] are used.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high whenever state != IDLE.
- tx_doneTick  output  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; tx = 1; tx_busy = 0; tx_doneTick = 0.
  - Tick counter, bit counter, shift register and parity accumulator are all cleared.
  - Asserting rst_n mid-frame aborts the frame immediately; tx returns to 1 with no done tick.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - 4-bit tick counter s_cnt; 3-bit bit counter n_cnt.
  - s_cnt increments only on clk edges where s_tick = 1.
- IDLE:
  - tx = 1.
  - On tx_start = 1: latch tx_dataIn into the shift register, clear s_cnt and parity, go to START.
  - tx drives 0 from the next clk edge, so tx_start-to-tx-fall latency is 1 clk.
  - s_tick is not required for the start.
- START:
  - tx = 0.
  - On s_tick with s_cnt = 15: s_cnt <= 0, n_cnt <= 0, go to DATA. Otherwise s_cnt++ on s_tick.
- DATA:
  - tx = shift register bit 0.
  - On s_tick with s_cnt = 15: XOR the bit into parity, shift the register right, s_cnt <= 0.
  - If n_cnt = DBIT-1, go to PARITY when PARITY_EN = 1, else STOP. Otherwise n_cnt++.
- PARITY:
  - tx = parity ^ PARITY_ODD.
  - Held 16 s_ticks, then go to STOP.
- STOP:
  - tx = 1.
  - On s_tick with s_cnt = SB_TICK-1: go to IDLE and pulse tx_doneTick for exactly that one clk. Otherwise s_cnt++ on s_tick.
  - s_cnt is wide enough for SB_TICK up to 32; it widens to 5 bits when SB_TICK > 16.
- tx_start outside IDLE is ignored, with no queuing. Changes on tx_dataIn after the latch have no effect on the frame in flight.
- Back-to-back frames:
  - tx_start held high, or asserted in the same cycle tx_doneTick fires, is seen in IDLE on the following clk.
  - The next START begins 1 clk after the return to IDLE, so the minimum idle gap is 1 clk of tx = 1.
- Frame length = 16·(1 + DBIT + PARITY_EN) + SB_TICK s_ticks.
- tx is glitch-free: driven from a flop, never combinationally from the state.

Test Plan:
- Reset:
  - Stimulus: rst_n low during DATA of a 0x55 frame.
  - Required: tx = 1, tx_busy = 0, tx_doneTick = 0 immediately (async); after release, tx stays 1 until tx_start.
- 0x55, defaults, s_tick from baud gen divsr = 650 (clk period 10 ns):
  - tx waveform: 0,1,0,1,0,1,0,1,0,1.
  - Each bit = 16 s_ticks (≈104.16 µs).
  - tx_doneTick fires once, 160 s_ticks after start.
  - A loopback receiver outputs rx_dataOut = 0x55.
- 0x0F then 0xFF, tx_start held high:
  - Two frames back-to-back, separated by a 1-clk idle gap.
  - Data bits sent as 1111 0000 then all 1s.
  - Two tx_doneTick pulses.
- tx_start pulsed during DATA with tx_dataIn = 0xA5:
  - Ignored; the current frame completes unchanged.
  - Only one tx_doneTick.
- PARITY_EN = 1, PARITY_ODD = 0, data 0x07:
  - Parity bit = 1 after bit 7; frame = 176 s_ticks.
  - With PARITY_ODD = 1, parity bit = 0.
- SB_TICK = 32, data 0x00:
  - Stop-high period = 32 s_ticks.
  - tx_doneTick asserts on the 32nd stop s_tick; tx_busy falls the same edge.
